// File: rtl/md_sequencer_pkg.sv
// Shared constants for the multiply/divide sequencer: FSM state codes,
// HI/LO store-select encodings and default parameter values.
package md_seq_pkg;

    localparam int DEFAULT_WIDTH          = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 64;

    localparam logic [1:0] STOREMD_DIV  = 2'b01;
    localparam logic [1:0] STOREMD_MULT = 2'b10;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MULT_RUN = 3'd1;
    localparam logic [2:0] ST_DIV_RUN  = 3'd2;
    localparam logic [2:0] ST_COMMIT   = 3'd3;
    localparam logic [2:0] ST_FAULT    = 3'd4;

endpackage

// File: rtl/md_sequencer_if.sv
// Request, unit handshake and HI/LO result bundle between the control unit,
// the shared multiplier/divider and the sequencer.
interface md_sequencer_if
    import md_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             multOp;
    logic             divOp;
    logic [1:0]       StoreMD;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             mult_start;
    logic             div_start;
    logic             mult_done;
    logic             div_done;
    logic [WIDTH-1:0] mult_hi;
    logic [WIDTH-1:0] mult_lo;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             md_busy;
    logic             md_done;
    logic             div_zero;
    logic             md_timeout;
    logic             op_illegal;

    // The sequencer side.
    modport slave (
        input  multOp, divOp, StoreMD, opA, opB,
        input  mult_done, div_done, mult_hi, mult_lo, div_quot, div_rem,
        output md_a, md_b, mult_start, div_start,
        output hi, lo, md_busy, md_done, div_zero, md_timeout, op_illegal
    );

    // The control unit plus arithmetic units side.
    modport master (
        output multOp, divOp, StoreMD, opA, opB,
        output mult_done, div_done, mult_hi, mult_lo, div_quot, div_rem,
        input  md_a, md_b, mult_start, div_start,
        input  hi, lo, md_busy, md_done, div_zero, md_timeout, op_illegal
    );

endinterface

// File: rtl/md_sequencer_watchdog.sv
// Run-length watchdog: counts cycles while enabled and raises a registered
// expire flag in the cycle the count reaches TIMEOUT_CYCLES-1.
module md_watchdog
    import md_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int            CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc = count + CW'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            expire <= 1'b0;
        end else if (enable) begin
            count  <= count_inc;
            expire <= (count_inc == LAST);
        end
    end

endmodule

// File: rtl/md_sequencer.sv
// Sequences the shared multiplier/divider: validates a request, latches the
// operands, starts one unit, waits for its done and commits HI/LO.
module md_sequencer
    import md_seq_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    md_sequencer_if.slave bus
);
    logic [2:0]       state;
    logic [2:0]       state_next;
    logic             run;
    logic             req_illegal;
    logic             req_div_zero;
    logic             own_done;
    logic             done_seen;
    logic             expire;

    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             mult_start;
    logic             div_start;
    logic             md_busy;
    logic             md_done;
    logic             div_zero;
    logic             md_timeout;
    logic             op_illegal;

    assign run          = (state == ST_MULT_RUN) || (state == ST_DIV_RUN);
    assign req_illegal  = (bus.multOp && bus.divOp)
                       || (bus.multOp && (bus.StoreMD != STOREMD_MULT))
                       || (bus.divOp  && (bus.StoreMD != STOREMD_DIV));
    assign req_div_zero = bus.divOp && (bus.opB == '0);
    assign own_done     = (state == ST_MULT_RUN) ? bus.mult_done : bus.div_done;
    // The start pulse marks the first RUN cycle, where the unit cannot be done yet.
    assign done_seen    = run && own_done && !(mult_start || div_start);

    md_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .reset (reset),
        .clear (!run),
        .enable(run),
        .expire(expire)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_illegal || req_div_zero) state_next = ST_FAULT;
                else if (bus.multOp)             state_next = ST_MULT_RUN;
                else if (bus.divOp)              state_next = ST_DIV_RUN;
            end
            ST_MULT_RUN, ST_DIV_RUN: begin
                if (done_seen)   state_next = ST_COMMIT;
                else if (expire) state_next = ST_FAULT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            md_a       <= '0;
            md_b       <= '0;
            hi         <= '0;
            lo         <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            md_busy    <= 1'b0;
            md_done    <= 1'b0;
            div_zero   <= 1'b0;
            md_timeout <= 1'b0;
            op_illegal <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register here sees the pre-edge state.
            state      <= state_next;
            mult_start <= (state == ST_IDLE) && (state_next == ST_MULT_RUN);
            div_start  <= (state == ST_IDLE) && (state_next == ST_DIV_RUN);
            md_busy    <= (state_next == ST_MULT_RUN) || (state_next == ST_DIV_RUN);
            md_done    <= (state_next == ST_COMMIT);
            op_illegal <= (state == ST_IDLE) && req_illegal;
            div_zero   <= (state == ST_IDLE) && !req_illegal && req_div_zero;
            md_timeout <= run && !done_seen && expire;

            if ((state == ST_IDLE)
                && ((state_next == ST_MULT_RUN) || (state_next == ST_DIV_RUN))) begin
                md_a <= bus.opA;
                md_b <= bus.opB;
            end

            // Divider convention: remainder lands in HI, quotient in LO.
            if (done_seen) begin
                if (state == ST_MULT_RUN) begin
                    hi <= bus.mult_hi;
                    lo <= bus.mult_lo;
                end else begin
                    hi <= bus.div_rem;
                    lo <= bus.div_quot;
                end
            end
        end
    end

    assign bus.md_a       = md_a;
    assign bus.md_b       = md_b;
    assign bus.hi         = hi;
    assign bus.lo         = lo;
    assign bus.mult_start = mult_start;
    assign bus.div_start  = div_start;
    assign bus.md_busy    = md_busy;
    assign bus.md_done    = md_done;
    assign bus.div_zero   = div_zero;
    assign bus.md_timeout = md_timeout;
    assign bus.op_illegal = op_illegal;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: each operation is expanded into a per-cycle timeline
// of expected outputs that a negedge compare process checks against the DUT.
module tb_md_sequencer;
    import md_seq_pkg::*;

    localparam int T = 8;

    typedef struct {
        logic        mult_start;
        logic        div_start;
        logic        md_busy;
        logic        md_done;
        logic        div_zero;
        logic        md_timeout;
        logic        op_illegal;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] md_a;
        logic [31:0] md_b;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } pin_t;

    logic clk;
    logic reset;

    md_sequencer_if #(.WIDTH(32)) bus ();

    md_sequencer #(
        .WIDTH         (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        exp_q[$];
    pin_t        pin_q[$];
    logic [31:0] m_hi, m_lo, m_a, m_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy_cnt = 0, done_cnt = 0, start_cnt = 0, dz_cnt = 0, ill_cnt = 0;
    int last_mstart_cyc = 0, last_to_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: owns all counters and every comparison.
    initial begin
        exp_t e;
        pin_t p;
        logic [6:0] act_p, exp_p;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.md_busy === 1'b1)    busy_cnt++;
            if (bus.md_done === 1'b1)    done_cnt++;
            if (bus.mult_start === 1'b1 || bus.div_start === 1'b1) start_cnt++;
            if (bus.mult_start === 1'b1) last_mstart_cyc = cyc;
            if (bus.md_timeout === 1'b1) last_to_cyc = cyc;
            if (bus.div_zero === 1'b1)   dz_cnt++;
            if (bus.op_illegal === 1'b1) ill_cnt++;
            while (pin_q.size() > 0) begin
                p = pin_q.pop_front();
                check(p.name, p.act, p.exp);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act_p = {bus.mult_start, bus.div_start, bus.md_busy, bus.md_done,
                         bus.div_zero, bus.md_timeout, bus.op_illegal};
                exp_p = {e.mult_start, e.div_start, e.md_busy, e.md_done,
                         e.div_zero, e.md_timeout, e.op_illegal};
                check($sformatf("cyc%0d pulses{ms,ds,busy,done,dz,to,ill}", cyc), 32'(act_p), 32'(exp_p));
                check($sformatf("cyc%0d hi", cyc),   bus.hi,   e.hi);
                check($sformatf("cyc%0d lo", cyc),   bus.lo,   e.lo);
                check($sformatf("cyc%0d md_a", cyc), bus.md_a, e.md_a);
                check($sformatf("cyc%0d md_b", cyc), bus.md_b, e.md_b);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "time limit");
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e.mult_start = 1'b0;
        e.div_start  = 1'b0;
        e.md_busy    = 1'b0;
        e.md_done    = 1'b0;
        e.div_zero   = 1'b0;
        e.md_timeout = 1'b0;
        e.op_illegal = 1'b0;
        e.hi         = m_hi;
        e.lo         = m_lo;
        e.md_a       = m_a;
        e.md_b       = m_b;
        return e;
    endfunction

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        pin_t p;
        p.name = name;
        p.act  = act;
        p.exp  = exp;
        pin_q.push_back(p);
    endtask

    // Advance one edge; e describes the outputs expected right after it.
    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        exp_q.push_back(e);
    endtask

    task automatic drive_junk();
        bus.multOp    = 1'($urandom_range(0, 1));
        bus.divOp     = 1'($urandom_range(0, 1));
        bus.StoreMD   = 2'($urandom_range(0, 3));
        bus.opA       = $urandom;
        bus.opB       = $urandom;
        bus.mult_done = 1'($urandom_range(0, 1));
        bus.div_done  = 1'($urandom_range(0, 1));
        bus.mult_hi   = $urandom;
        bus.mult_lo   = $urandom;
        bus.div_quot  = $urandom;
        bus.div_rem   = $urandom;
    endtask

    task automatic do_gap();
        drive_junk();
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        step(idle_exp());
    endtask

    // A request the sequencer must reject: illegal encoding beats divide-by-zero.
    task automatic do_fault(input logic m, input logic dv, input logic [1:0] s, input logic [31:0] b);
        exp_t e;
        logic ill;
        drive_junk();
        bus.multOp  = m;
        bus.divOp   = dv;
        bus.StoreMD = s;
        bus.opB     = b;
        ill = (m && dv) || (m && s != STOREMD_MULT) || (dv && s != STOREMD_DIV);
        e = idle_exp();
        e.op_illegal = ill;
        e.div_zero   = !ill && dv && (b == 0);
        step(e);
        drive_junk();
        step(idle_exp());
    endtask

    // Valid request; own done is held high from run cycle d on (d >= T means never sampled).
    task automatic do_valid(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                            input int d, input bit fixed, input logic [31:0] r_hi,
                            input logic [31:0] r_lo);
        exp_t e;
        logic own;
        drive_junk();
        bus.multOp  = is_mult;
        bus.divOp   = !is_mult;
        bus.StoreMD = is_mult ? STOREMD_MULT : STOREMD_DIV;
        bus.opA     = a;
        bus.opB     = b;
        m_a = a;
        m_b = b;
        e = idle_exp();
        e.mult_start = is_mult;
        e.div_start  = !is_mult;
        e.md_busy    = 1'b1;
        step(e);
        for (int k = 0; k < T; k++) begin
            drive_junk();
            own = (k == 0) ? 1'($urandom_range(0, 1)) : (k >= d);
            if (is_mult) bus.mult_done = own;
            else         bus.div_done  = own;
            if (fixed) begin
                bus.mult_hi  = r_hi;
                bus.mult_lo  = r_lo;
                bus.div_rem  = r_hi;
                bus.div_quot = r_lo;
            end
            if (k >= 1 && own) begin
                m_hi = is_mult ? bus.mult_hi : bus.div_rem;
                m_lo = is_mult ? bus.mult_lo : bus.div_quot;
                e = idle_exp();
                e.md_done = 1'b1;
                step(e);
                break;
            end else if (k == T - 1) begin
                e = idle_exp();
                e.md_timeout = 1'b1;
                step(e);
                break;
            end else begin
                e = idle_exp();
                e.md_busy = 1'b1;
                step(e);
            end
        end
        drive_junk();
        step(idle_exp());
    endtask

    initial begin
        int s_busy, s_done, s_start, s_dz, s_ill;
        exp_t e;
        logic [31:0] b;
        int d;

        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
        reset = 1'b0;
        drive_junk();
        step(idle_exp());
        step(idle_exp());
        reset = 1'b1;
        bus.multOp = 1'b0;
        bus.divOp  = 1'b0;
        step(idle_exp());
        pin("reset hi", bus.hi, 32'd0);
        pin("reset lo", bus.lo, 32'd0);

        // 1: 7*6, done held from the fourth busy cycle on.
        s_busy = busy_cnt; s_done = done_cnt; s_start = start_cnt;
        do_valid(1'b1, 32'd7, 32'd6, 3, 1'b1, 32'd0, 32'd42);
        pin("t1 hi", bus.hi, 32'd0);
        pin("t1 lo", bus.lo, 32'd42);
        pin("t1 busy cycles", 32'(busy_cnt - s_busy), 32'd4);
        pin("t1 starts", 32'(start_cnt - s_start), 32'd1);
        pin("t1 md_done pulses", 32'(done_cnt - s_done), 32'd1);

        // 2: 17/5 -> quot 3, rem 2, earliest possible done.
        s_done = done_cnt;
        do_valid(1'b0, 32'd17, 32'd5, 1, 1'b1, 32'd2, 32'd3);
        pin("t2 hi", bus.hi, 32'd2);
        pin("t2 lo", bus.lo, 32'd3);
        pin("t2 md_done pulses", 32'(done_cnt - s_done), 32'd1);

        // 3: divide by zero.
        s_busy = busy_cnt; s_start = start_cnt; s_dz = dz_cnt;
        do_fault(1'b0, 1'b1, STOREMD_DIV, 32'd0);
        pin("t3 hi", bus.hi, 32'd2);
        pin("t3 lo", bus.lo, 32'd3);
        pin("t3 busy cycles", 32'(busy_cnt - s_busy), 32'd0);
        pin("t3 starts", 32'(start_cnt - s_start), 32'd0);
        pin("t3 div_zero pulses", 32'(dz_cnt - s_dz), 32'd1);

        // 4: mult that never finishes.
        do_valid(1'b1, 32'd9, 32'd9, 100, 1'b0, 32'd0, 32'd0);
        pin("t4 start-to-timeout cycles", 32'(last_to_cyc - last_mstart_cyc), 32'd8);
        pin("t4 hi", bus.hi, 32'd2);
        pin("t4 lo", bus.lo, 32'd3);

        // 5: both requests, and mult with the div store select.
        s_start = start_cnt; s_ill = ill_cnt;
        do_fault(1'b1, 1'b1, STOREMD_MULT, 32'd4);
        do_fault(1'b1, 1'b0, STOREMD_DIV, 32'd4);
        pin("t5 op_illegal pulses", 32'(ill_cnt - s_ill), 32'd2);
        pin("t5 starts", 32'(start_cnt - s_start), 32'd0);
        pin("t5 lo", bus.lo, 32'd3);

        // 6: reset during DIV_RUN, then a late div_done in IDLE.
        s_done = done_cnt;
        drive_junk();
        bus.multOp = 1'b0; bus.divOp = 1'b1; bus.StoreMD = STOREMD_DIV;
        bus.opA = 32'd100; bus.opB = 32'd7;
        m_a = 32'd100; m_b = 32'd7;
        e = idle_exp(); e.div_start = 1'b1; e.md_busy = 1'b1;
        step(e);
        drive_junk(); bus.div_done = 1'b0;
        e = idle_exp(); e.md_busy = 1'b1;
        step(e);
        reset = 1'b0;
        drive_junk();
        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
        step(idle_exp());
        reset = 1'b1;
        drive_junk();
        bus.multOp = 1'b0; bus.divOp = 1'b0; bus.div_done = 1'b1;
        step(idle_exp());
        step(idle_exp());
        pin("t6 hi", bus.hi, 32'd0);
        pin("t6 lo", bus.lo, 32'd0);
        pin("t6 md_done pulses", 32'(done_cnt - s_done), 32'd0);
        do_valid(1'b1, 32'd3, 32'd5, 2, 1'b1, 32'd0, 32'd15);
        pin("t6 next lo", bus.lo, 32'd15);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1: do_gap();
                2: begin
                    logic m, dv;
                    logic [1:0] s;
                    do begin
                        m  = 1'($urandom_range(0, 1));
                        dv = 1'($urandom_range(0, 1));
                        s  = 2'($urandom_range(0, 3));
                    end while (!((m && dv) || (m && s != STOREMD_MULT) || (dv && s != STOREMD_DIV)));
                    do_fault(m, dv, s, $urandom);
                end
                3: do_fault(1'b0, 1'b1, STOREMD_DIV, 32'd0);
                default: begin
                    case ($urandom_range(0, 3))
                        0:       d = 1;
                        1:       d = $urandom_range(2, T - 1);
                        2:       d = T - 1;
                        default: d = T + $urandom_range(0, 3);
                    endcase
                    b = $urandom;
                    if (b == 0) b = 32'd1;
                    do_valid(1'($urandom_range(0, 1)), $urandom, b, d, 1'b0, 32'd0, 32'd0);
                end
            endcase
        end

        do_gap();
        do_gap();
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
